// File: rtl/pp_databuffer_pkg.sv
// Shared types and helpers for the ping-pong data buffer.
// Bank state encoding, address-width computation and bit reversal.
package pp_databuffer_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Reverses the low w bits of a; upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < w; i++) begin
            r[i] = a[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pp_bank_mem.sv
// One buffer bank: LANES-wide write port and LANES-wide registered read port.
// Only the read register is reset; the storage array keeps its contents.
module pp_bank_mem #(
    parameter int unsigned DATA_W = 56,
    parameter int unsigned LANES  = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      reset_i,
    input  logic                      we_i,
    input  logic [LANES*ADDR_W-1:0]   waddr_i,
    input  logic [LANES*DATA_W-1:0]   wdata_i,
    input  logic                      re_i,
    input  logic [LANES*ADDR_W-1:0]   raddr_i,
    output logic [LANES*DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [LANES*DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                mem[waddr_i[k*ADDR_W +: ADDR_W]] <= wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Read register holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                rdata_q[k*DATA_W +: DATA_W] <= mem[raddr_i[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pp_databuffer.sv
// Two-bank ping-pong buffer: writer fills one bank while the reader consumes the other.
// Define PP_DATABUFFER_BITREV_EN to store samples at bit-reversed addresses.
module pp_databuffer
    import pp_databuffer_pkg::*;
#(
    parameter  int unsigned DATA_W = 56,
    parameter  int unsigned LANES  = 8,
    parameter  int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [LANES*DATA_W-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [LANES*ADDR_W-1:0] rd_addr,
    input  logic                    rd_release,
    output logic                    rd_valid,
    output logic [LANES*DATA_W-1:0] rd_data,
    output logic                    frame_done,
    output logic                    wr_bank,
    output logic                    rd_bank,
    output logic                    overflow
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - LANES);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              rd_sel_q, rd_sel_d;
    logic              rd_valid_q;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;
    bank_state_e       bank_q [2];
    bank_state_e       bank_d [2];

    logic                    wr_fire, wr_last, rd_fire, rel_fire;
    logic [LANES*ADDR_W-1:0] waddr;
    logic [1:0]              mem_we, mem_re;
    logic [LANES*DATA_W-1:0] mem_rdata [2];

    assign wr_ready = (bank_q[wr_bank_q] == BANK_EMPTY);
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_last  = wr_fire && (wr_ptr_q == LAST_PTR);
    assign rd_fire  = rd_en && (bank_q[rd_bank_q] == BANK_FULL);
    assign rel_fire = rd_release && (bank_q[rd_bank_q] == BANK_FULL);

    // Writer only touches an EMPTY bank and the reader only releases a FULL one,
    // so a fill and a release in the same cycle always hit different banks.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        rd_sel_d     = rd_sel_q;
        bank_d       = bank_q;
        frame_done_d = wr_last;
        overflow_d   = overflow_q | (wr_valid & ~wr_ready);
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(LANES);
        end
        if (wr_last) begin
            wr_ptr_d  = '0;
            wr_bank_d = ~wr_bank_q;
        end
        if (rel_fire) begin
            rd_bank_d = ~rd_bank_q;
        end
        if (rd_fire) begin
            rd_sel_d = rd_bank_q;
        end
        for (int unsigned b = 0; b < 2; b++) begin
            if (wr_last && (wr_bank_q == 1'(b))) bank_d[b] = BANK_FULL;
            if (rel_fire && (rd_bank_q == 1'(b))) bank_d[b] = BANK_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_sel_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            bank_q[0]    <= BANK_EMPTY;
            bank_q[1]    <= BANK_EMPTY;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            rd_sel_q     <= rd_sel_d;
            rd_valid_q   <= rd_fire;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            bank_q[0]    <= bank_d[0];
            bank_q[1]    <= bank_d[1];
        end
    end

    always_comb begin
        waddr = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
`ifdef PP_DATABUFFER_BITREV_EN
            waddr[k*ADDR_W +: ADDR_W] = ADDR_W'(bitrev(32'(wr_ptr_q + ADDR_W'(k)), ADDR_W));
`else
            waddr[k*ADDR_W +: ADDR_W] = wr_ptr_q + ADDR_W'(k);
`endif
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign mem_we[b] = wr_fire && (wr_bank_q == 1'(b));
        assign mem_re[b] = rd_fire && (rd_bank_q == 1'(b));

        pp_bank_mem #(
            .DATA_W(DATA_W),
            .LANES (LANES),
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W)
        ) u_mem (
            .clk    (clk),
            .reset_i(reset),
            .we_i   (mem_we[b]),
            .waddr_i(waddr),
            .wdata_i(wr_data),
            .re_i   (mem_re[b]),
            .raddr_i(rd_addr),
            .rdata_o(mem_rdata[b])
        );
    end

    // Each bank's read register only updates on its own accepted read, so
    // selecting by the last-read bank keeps rd_data stable on rejected reads.
    assign rd_data    = rd_sel_q ? mem_rdata[1] : mem_rdata[0];
    assign rd_valid   = rd_valid_q;
    assign frame_done = frame_done_q;
    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/pp_databuffer.md
PP_DATABUFFER -- requirements
Module: pp_databuffer

Interface
REQ-001 The block SHALL take parameter DATA_W, default 56, meaning the width of one complex sample word.
REQ-002 The block SHALL take parameter LANES, default 8, meaning the number of words written and read per beat; it must be a power of 2.
REQ-003 The block SHALL take parameter DEPTH, default 256, meaning the words per bank; it must be a power of 2 and a multiple of LANES. ADDR_W = log2(DEPTH).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 Port wr_valid, input, 1 bit: a write beat is offered.
REQ-007 Port wr_ready, output, 1 bit: the current write bank is EMPTY.
REQ-008 Port wr_data, input, LANES*DATA_W bits: lane k is bits [k*DATA_W +: DATA_W].
REQ-009 Port rd_en, input, 1 bit: read request.
REQ-010 Port rd_addr, input, LANES*ADDR_W bits: per-lane read address.
REQ-011 Port rd_release, input, 1 bit: the consumer has finished the current read bank.
REQ-012 Port rd_valid, output, 1 bit: rd_data holds the result of an accepted read.
REQ-013 Port rd_data, output, LANES*DATA_W bits: per-lane read data.
REQ-014 Port frame_done, output, 1 bit: one-cycle pulse when a bank fills.
REQ-015 Port wr_bank / rd_bank, output, 1 bit each: current bank indices.
REQ-016 Port overflow, output, 1 bit: sticky flag, set by wr_valid while wr_ready=0.

Function
REQ-017 Each bank SHALL hold a registered state of EMPTY or FULL.
REQ-018 A write beat SHALL be accepted when wr_valid and wr_ready are both high; wr_ready is a function of registered state only.
REQ-019 Each accepted beat SHALL store lane k at address wr_ptr+k of bank wr_bank, then advance wr_ptr by LANES, wrapping modulo DEPTH.
REQ-020 On the beat that writes address DEPTH-1, the block SHALL, on the next edge, mark the bank FULL, toggle wr_bank, clear wr_ptr to 0 and pulse frame_done for one cycle.
REQ-021 A read SHALL be accepted when rd_en is high and bank rd_bank is FULL; rd_data and rd_valid then update one cycle later.
REQ-022 A read SHALL NOT be accepted when rd_bank is not FULL; in that case rd_valid=0 on the next cycle and rd_data holds its last value.
REQ-023 rd_release with bank rd_bank FULL SHALL mark the bank EMPTY and toggle rd_bank; rd_release with the bank not FULL SHALL be ignored.
REQ-024 When the writer fills bank X in the same cycle that rd_release frees bank Y, both transitions SHALL occur.
REQ-025 When rd_en and rd_release occur in the same cycle, the read SHALL complete from the old bank before the release takes effect.
REQ-026 Reads and writes SHALL never target the same bank, so no read-during-write hazard exists.

Reset
REQ-027 On reset, wr_ptr, wr_bank, rd_bank, rd_valid, frame_done, overflow and rd_data SHALL be 0, and both banks EMPTY, so wr_ready=1 on the first cycle after reset.
REQ-028 Reset mid-frame SHALL discard partial and full banks; memory contents are not cleared.

Configuration
REQ-029 With PP_DATABUFFER_BITREV_EN defined, the write address SHALL be bitrev_ADDR_W(wr_ptr+k), giving bit-reversed FFT input ordering; without it, the address is natural order.

Structure
REQ-030 Package pp_databuffer_pkg SHALL hold the bank-state enum (EMPTY/FULL), the ADDR_W computation and the bit-reverse function.
REQ-031 Sub-module pp_bank_mem SHALL implement one bank with a LANES-wide write port and a LANES-wide registered read port; the block instantiates it twice.

Verification
REQ-032 Reset, then 32 beats of lane values 8i+k -> frame_done pulses after beat 32, wr_ready=0 is not asserted yet, and wr_bank=1.
REQ-033 With rd_addr = 8j+k for j=0..31 -> rd_data lane k = 8j+k, with rd_valid one cycle after each rd_en.
REQ-034 Fill both banks without a release -> wr_ready=0; one more wr_valid sets overflow=1, and memory is unchanged.
REQ-035 rd_release together with the last beat of the other bank -> rd_bank toggles, the bank is EMPTY, and the filled bank is FULL in the same cycle.
REQ-036 Build with PP_DATABUFFER_BITREV_EN, DEPTH=16, LANES=4, writing 0..15 -> reading address 1 returns 8 and address 3 returns 12.
REQ-037 Assert reset mid-frame at beat 10 -> all outputs are 0, wr_ready=1, and the next frame writes from address 0.
